// File: rtl/fproc_meas_sched_if.sv
// Bundle of measurement inputs and per-core fproc request/response signals.
interface fproc_meas_sched_if #(
  parameter int N_CORES = 5,
  parameter int N_MEAS  = 5,
  parameter int DATA_W  = 32,
  parameter int ID_W    = (N_MEAS > 1) ? $clog2(N_MEAS) : 1
);
  logic [N_MEAS-1:0]         meas;
  logic [N_MEAS-1:0]         meas_valid;
  logic                      meas_clear;
  logic [N_CORES-1:0]        core_enable;
  logic [N_CORES*ID_W-1:0]   core_id;
  logic [N_CORES-1:0]        core_ready;
  logic [N_CORES*DATA_W-1:0] core_data;
  logic [N_MEAS-1:0]         meas_overrun;
  logic [N_CORES-1:0]        core_err;

  modport master (
    output meas, meas_valid, meas_clear, core_enable, core_id,
    input  core_ready, core_data, meas_overrun, core_err
  );

  modport slave (
    input  meas, meas_valid, meas_clear, core_enable, core_id,
    output core_ready, core_data, meas_overrun, core_err
  );
endinterface

// File: rtl/fproc_meas_sched.sv
// Latches measurement results and serves per-core fproc reads round-robin, one consumed result per grant.
// Responses are registered: eligibility in cycle t gives core_ready at the following edge.
module fproc_meas_sched #(
  parameter int N_CORES = 5,
  parameter int N_MEAS  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input logic clk,
  input logic reset,
  fproc_meas_sched_if.slave bus
);
  localparam int ID_W  = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
  localparam int NPAD  = 1 << ID_W;
  localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} core_state_e;

  core_state_e              state_q [N_CORES];
  core_state_e              state_d [N_CORES];
  logic [ID_W-1:0]          id_q    [N_CORES];
  logic [ID_W-1:0]          id_d    [N_CORES];
  logic [TW-1:0]            timer_q [N_CORES];
  logic [TW-1:0]            timer_d [N_CORES];

  logic [N_MEAS-1:0]        result_q, pending_q, overrun_q, consumed;
  logic [NPAD-1:0]          pend_ext, res_ext;
  logic [PTR_W-1:0]         rr_ptr, grant_idx;
  logic                     grant_vld;
  logic [ID_W-1:0]          grant_id;
  logic [N_CORES-1:0]       eligible, grant_hit, timeout_hit, err_set, ready_q, err_q;
  logic [N_CORES*DATA_W-1:0] data_q;

  // Padding to a power of two makes out-of-range ids read as never pending.
  assign pend_ext = NPAD'(pending_q);
  assign res_ext  = NPAD'(result_q);

  always_comb begin
    for (int i = 0; i < N_CORES; i++)
      eligible[i] = (state_q[i] == S_WAIT) && pend_ext[id_q[i]];
  end

  // Scan downward so the last hit is the first eligible core at or after rr_ptr.
  always_comb begin
    int c;
    c         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_id  = '0;
    grant_hit = '0;
    for (int j = N_CORES - 1; j >= 0; j--) begin
      c = (int'(rr_ptr) + j) % N_CORES;
      if (eligible[c]) begin
        grant_vld    = 1'b1;
        grant_idx    = PTR_W'(c);
        grant_id     = id_q[c];
        grant_hit    = '0;
        grant_hit[c] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_MEAS; k++)
      consumed[k] = grant_vld && (grant_id == ID_W'(k));
  end

  // A core released this cycle sees itself IDLE, so a same-edge enable is accepted.
  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      state_d[i]     = state_q[i];
      id_d[i]        = id_q[i];
      timer_d[i]     = timer_q[i];
      err_set[i]     = 1'b0;
      timeout_hit[i] = 1'b0;
      case (state_q[i])
        S_WAIT: begin
          timer_d[i]     = timer_q[i] + 1'b1;
          timeout_hit[i] = (TIMEOUT > 0) && (timer_q[i] == TW'(TIMEOUT - 1)) && !grant_hit[i];
          if (grant_hit[i] || timeout_hit[i])
            state_d[i] = S_IDLE;
        end
        default: ;
      endcase
      if (bus.core_enable[i]) begin
        if (state_d[i] == S_IDLE) begin
          state_d[i] = S_WAIT;
          id_d[i]    = bus.core_id[i*ID_W +: ID_W];
          timer_d[i] = '0;
        end else begin
          err_set[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CORES; i++) begin
        state_q[i] <= S_IDLE;
        id_q[i]    <= '0;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        state_q[i] <= state_d[i];
        id_q[i]    <= id_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q  <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      rr_ptr    <= '0;
      ready_q   <= '0;
      data_q    <= '0;
      err_q     <= '0;
    end else begin
      // A capture on the consuming edge keeps the channel pending and is not an overrun.
      for (int k = 0; k < N_MEAS; k++) begin
        if (bus.meas_valid[k]) begin
          result_q[k]  <= bus.meas[k];
          pending_q[k] <= 1'b1;
        end else if (bus.meas_clear || consumed[k]) begin
          pending_q[k] <= 1'b0;
        end
        if (bus.meas_valid[k] && pending_q[k] && !consumed[k])
          overrun_q[k] <= 1'b1;
        else if (bus.meas_clear)
          overrun_q[k] <= 1'b0;
      end
      if (grant_vld)
        rr_ptr <= (grant_idx == PTR_W'(N_CORES - 1)) ? '0 : grant_idx + 1'b1;
      ready_q <= grant_hit | timeout_hit;
      data_q  <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        data_q[i*DATA_W]     <= grant_hit[i] & res_ext[id_q[i]];
        data_q[i*DATA_W + 1] <= timeout_hit[i];
      end
      err_q <= err_q | err_set;
    end
  end

  assign bus.core_ready   = ready_q;
  assign bus.core_data    = data_q;
  assign bus.meas_overrun = overrun_q;
  assign bus.core_err     = err_q;
endmodule

// File: tb/tb_fproc_meas_sched.sv
// Bench: directed vector table, randomized run against a reference model, timeout and async-reset sequences.
module tb_fproc_meas_sched;
  localparam int NC = 5;
  localparam int NM = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  fproc_meas_sched_if #(.N_CORES(NC), .N_MEAS(NM), .DATA_W(DW)) bus0 ();
  fproc_meas_sched_if #(.N_CORES(NC), .N_MEAS(NM), .DATA_W(DW)) bus1 ();

  fproc_meas_sched #(.N_CORES(NC), .N_MEAS(NM), .DATA_W(DW), .TIMEOUT(0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  fproc_meas_sched #(.N_CORES(NC), .N_MEAS(NM), .DATA_W(DW), .TIMEOUT(8))
    dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  en;
    logic [14:0] ids;
    logic [4:0]  mv;
    logic [4:0]  m;
    logic        clr;
    logic [4:0]  rdy;
    logic [4:0]  d0;
    logic [4:0]  ovr;
    logic [4:0]  err;
  } vec_t;

  vec_t tbl [28];

  // Reference model state (TIMEOUT = 0 instance)
  bit   m_res [NM];
  bit   m_pend[NM];
  bit   m_ovr [NM];
  bit   m_err [NC];
  bit   m_wait[NC];
  int   m_id  [NC];
  int   m_rr;
  logic [4:0]   e_rdy, e_ovr, e_err;
  logic [159:0] e_data;

  function automatic logic [159:0] expand(input logic [4:0] b0, input logic [4:0] b1);
    logic [159:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) begin
      v[i*DW]     = b0[i];
      v[i*DW + 1] = b1[i];
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic [4:0] en, input logic [14:0] ids, input logic [4:0] mv,
                        input logic [4:0] m, input logic clr);
    bus0.core_enable = en;
    bus0.core_id     = ids;
    bus0.meas_valid  = mv;
    bus0.meas        = m;
    bus0.meas_clear  = clr;
  endtask

  task automatic drive1(input logic [4:0] en, input logic [14:0] ids, input logic [4:0] mv,
                        input logic [4:0] m);
    bus1.core_enable = en;
    bus1.core_id     = ids;
    bus1.meas_valid  = mv;
    bus1.meas        = m;
    bus1.meas_clear  = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NM; k++) begin m_res[k] = 0; m_pend[k] = 0; m_ovr[k] = 0; end
    for (int i = 0; i < NC; i++) begin m_err[i] = 0; m_wait[i] = 0; m_id[i] = 0; end
    m_rr = 0;
  endtask

  // One clock edge of the scheduler's rules: pick, respond, capture, accept requests.
  task automatic model_step(input logic [4:0] en, input logic [14:0] ids, input logic [4:0] mv,
                            input logic [4:0] m, input logic clr);
    int win, kc;
    win = -1;
    kc  = -1;
    for (int o = 0; o < NC; o++) begin
      int c;
      c = (m_rr + o) % NC;
      if (win < 0 && m_wait[c] && m_id[c] < NM) begin
        if (m_pend[m_id[c]]) win = c;
      end
    end
    e_rdy  = '0;
    e_data = '0;
    if (win >= 0) begin
      kc               = m_id[win];
      e_rdy[win]       = 1'b1;
      e_data[win * DW] = m_res[kc];
      m_wait[win]      = 0;
      m_rr             = (win + 1) % NC;
    end
    for (int k = 0; k < NM; k++) begin
      if (mv[k]) begin
        if (m_pend[k] && k != kc) m_ovr[k] = 1;
        m_res[k]  = m[k];
        m_pend[k] = 1;
      end else begin
        if (clr || k == kc) m_pend[k] = 0;
        if (clr) m_ovr[k] = 0;
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (en[i]) begin
        if (m_wait[i]) m_err[i] = 1;
        else begin
          m_wait[i] = 1;
          m_id[i]   = int'(ids[i*3 +: 3]);
        end
      end
    end
    for (int k = 0; k < NM; k++) e_ovr[k] = m_ovr[k];
    for (int i = 0; i < NC; i++) e_err[i] = m_err[i];
  endtask

  task automatic reset_all();
    drive0('0, '0, '0, '0, 1'b0);
    drive1('0, '0, '0, '0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  r_en, r_mv, r_m;
    logic [14:0] r_ids;
    logic        r_clr;

    // en, ids, mv, m, clr | rdy, d0, ovr, err
    tbl[0]  = '{5'b00001, 15'd2,     5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[1]  = '{5'b00000, 15'd0,     5'b00100, 5'b00100, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[2]  = '{5'b00000, 15'd0,     5'b00000, 5'b00000, 1'b0, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
    tbl[3]  = '{5'b00000, 15'd0,     5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[4]  = '{5'b00000, 15'd0,     5'b10010, 5'b10010, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[5]  = '{5'b01011, 15'd2057,  5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[6]  = '{5'b00000, 15'd0,     5'b00000, 5'b00000, 1'b0, 5'b00010, 5'b00010, 5'b00000, 5'b00000};
    tbl[7]  = '{5'b00000, 15'd0,     5'b00000, 5'b00000, 1'b0, 5'b01000, 5'b01000, 5'b00000, 5'b00000};
    tbl[8]  = '{5'b00000, 15'd0,     5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[9]  = '{5'b00000, 15'd0,     5'b00010, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[10] = '{5'b00000, 15'd0,     5'b00000, 5'b00000, 1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
    tbl[11] = '{5'b00000, 15'd0,     5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[12] = '{5'b00000, 15'd0,     5'b01000, 5'b01000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[13] = '{5'b00000, 15'd0,     5'b01000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b01000, 5'b00000};
    tbl[14] = '{5'b00000, 15'd0,     5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[15] = '{5'b00000, 15'd0,     5'b01000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[16] = '{5'b00100, 15'd192,   5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[17] = '{5'b00000, 15'd0,     5'b01000, 5'b01000, 1'b0, 5'b00100, 5'b00000, 5'b00000, 5'b00000};
    tbl[18] = '{5'b00100, 15'd192,   5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[19] = '{5'b00000, 15'd0,     5'b00000, 5'b00000, 1'b0, 5'b00100, 5'b00100, 5'b00000, 5'b00000};
    tbl[20] = '{5'b10000, 15'd28672, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[21] = '{5'b10000, 15'd0,     5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b10000};
    tbl[22] = '{5'b00000, 15'd0,     5'b11111, 5'b11111, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b10000};
    tbl[23] = '{5'b00001, 15'd0,     5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b10000};
    tbl[24] = '{5'b00000, 15'd0,     5'b00000, 5'b00000, 1'b0, 5'b00001, 5'b00001, 5'b00000, 5'b10000};
    tbl[25] = '{5'b00010, 15'd8,     5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b10000};
    tbl[26] = '{5'b00010, 15'd16,    5'b00000, 5'b00000, 1'b0, 5'b00010, 5'b00010, 5'b00000, 5'b10000};
    tbl[27] = '{5'b00000, 15'd0,     5'b00000, 5'b00000, 1'b0, 5'b00010, 5'b00010, 5'b00000, 5'b10000};

    drive0('0, '0, '0, '0, 1'b0);
    drive1('0, '0, '0, '0);
    #1;
    check("reset_ready", bus0.core_ready, '0);
    check("reset_data", bus0.core_data, '0);
    check("reset_ovr", bus0.meas_overrun, '0);
    check("reset_err", bus0.core_err, '0);
    reset_all();

    for (int r = 0; r < 28; r++) begin
      @(negedge clk);
      drive0(tbl[r].en, tbl[r].ids, tbl[r].mv, tbl[r].m, tbl[r].clr);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_ready", r), bus0.core_ready, tbl[r].rdy);
      check($sformatf("tbl%0d_data", r), bus0.core_data, expand(tbl[r].d0, 5'b0));
      check($sformatf("tbl%0d_ovr", r), bus0.meas_overrun, tbl[r].ovr);
      check($sformatf("tbl%0d_err", r), bus0.core_err, tbl[r].err);
    end

    reset_all();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      r_en = 5'($urandom) & 5'($urandom);
      for (int i = 0; i < NC; i++) r_ids[i*3 +: 3] = 3'($urandom_range(0, 4));
      r_mv  = 5'($urandom) & 5'($urandom) & 5'($urandom);
      r_m   = 5'($urandom);
      r_clr = (r_mv == 5'b0) && ($urandom_range(0, 31) == 0);
      drive0(r_en, r_ids, r_mv, r_m, r_clr);
      @(posedge clk);
      model_step(r_en, r_ids, r_mv, r_m, r_clr);
      #1;
      check($sformatf("rnd%0d_ready", cyc), bus0.core_ready, e_rdy);
      check($sformatf("rnd%0d_data", cyc), bus0.core_data, e_data);
      check($sformatf("rnd%0d_ovr", cyc), bus0.meas_overrun, e_ovr);
      check($sformatf("rnd%0d_err", cyc), bus0.core_err, e_err);
    end

    // Timeout instance: plain timeout on idle id0
    reset_all();
    @(negedge clk); drive1(5'b00100, 15'd0, '0, '0);
    @(posedge clk);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk); drive1('0, '0, '0, '0);
      @(posedge clk); #1;
      check($sformatf("to_ready_e%0d", j), bus1.core_ready, (j == 8) ? 5'b00100 : 5'b00000);
      if (j == 8) check("to_data", bus1.core_data, expand(5'b0, 5'b00100));
    end

    // Re-request during WAIT: flagged, timer unaffected
    @(negedge clk); drive1(5'b00100, 15'd0, '0, '0);
    @(posedge clk);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 3) drive1(5'b00100, 15'd64, '0, '0);
      else drive1('0, '0, '0, '0);
      @(posedge clk); #1;
      check($sformatf("toerr_ready_e%0d", j), bus1.core_ready, (j == 8) ? 5'b00100 : 5'b00000);
      if (j == 3) check("toerr_err", bus1.core_err, 5'b00100);
      if (j == 8) check("toerr_data", bus1.core_data, expand(5'b0, 5'b00100));
    end

    // Grant on the same cycle the timer expires wins
    @(negedge clk); drive1(5'b00100, 15'd0, '0, '0);
    @(posedge clk);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 7) drive1('0, '0, 5'b00001, 5'b00001);
      else drive1('0, '0, '0, '0);
      @(posedge clk); #1;
      check($sformatf("toprio_ready_e%0d", j), bus1.core_ready, (j == 8) ? 5'b00100 : 5'b00000);
      if (j == 8) check("toprio_data", bus1.core_data, expand(5'b00100, 5'b0));
    end

    // Invalid id is only released by the timeout
    @(negedge clk); drive1(5'b00010, 15'd48, 5'b11111, 5'b11111);
    @(posedge clk);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk); drive1('0, '0, '0, '0);
      @(posedge clk); #1;
      check($sformatf("toinv_ready_e%0d", j), bus1.core_ready, (j == 8) ? 5'b00010 : 5'b00000);
      if (j == 8) check("toinv_data", bus1.core_data, expand(5'b0, 5'b00010));
    end

    // Asynchronous reset mid-WAIT with pending and sticky flags set
    reset_all();
    @(negedge clk); drive0('0, '0, 5'b00010, 5'b00010, 1'b0);
    @(posedge clk);
    @(negedge clk); drive0(5'b00100, 15'd192, 5'b00010, 5'b00000, 1'b0);
    @(posedge clk);
    @(negedge clk); drive0(5'b00100, 15'd192, '0, '0, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_ovr", bus0.meas_overrun, 5'b00010);
    check("pre_rst_err", bus0.core_err, 5'b00100);
    @(negedge clk); drive0('0, '0, '0, '0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_ready", bus0.core_ready, '0);
    check("arst_data", bus0.core_data, '0);
    check("arst_ovr", bus0.meas_overrun, '0);
    check("arst_err", bus0.core_err, '0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); drive0(5'b00101, 15'd193, '0, '0, 1'b0);
    @(posedge clk); #1;
    check("post_rst_err", bus0.core_err, '0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); drive0('0, '0, '0, '0, 1'b0);
      @(posedge clk); #1;
      check($sformatf("post_rst_nopend%0d", j), bus0.core_ready, '0);
    end
    @(negedge clk); drive0('0, '0, 5'b00010, 5'b00010, 1'b0);
    @(posedge clk); #1;
    check("post_rst_lat1", bus0.core_ready, '0);
    @(negedge clk); drive0('0, '0, '0, '0, 1'b0);
    @(posedge clk); #1;
    check("post_rst_lat2", bus0.core_ready, 5'b00001);
    check("post_rst_data", bus0.core_data, expand(5'b00001, 5'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
